sd_block_responder: RTL and testbench
=====================================

SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 Parameter VDNUM, default 3: number of virtual-disk channels served; range 1..4.
REQ-002 Parameter ACK_DELAY, default 4: idle cycles between request acceptance and sd_ack assertion; range 0..255.
REQ-003 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 sd_lba  in  32*VDNUM  per-channel block number, channel n at bits [32n+31:32n].
REQ-006 sd_rd  in  VDNUM  per-channel read request (level).
REQ-007 sd_wr  in  VDNUM  per-channel write request (level).
REQ-008 sd_ack  out  VDNUM  one-hot acknowledge, held for the whole transfer.
REQ-009 sd_buff_addr  out  9  byte offset within the 512-byte block.
REQ-010 sd_buff_dout  out  8  read data toward the requester.
REQ-011 sd_buff_din  in  8*VDNUM  per-channel write data from the requester, valid 1 cycle after sd_buff_addr changes.
REQ-012 sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout valid at sd_buff_addr.
REQ-013 mem_addr  out  41  backing-store byte address {lba, offset}.
REQ-014 mem_rd / mem_wr  out  1 each  backing-store request, held until mem_ready.
REQ-015 mem_wdata  out  8  / mem_rdata  in  8  backing-store data.
REQ-016 mem_ready  in  1  one-cycle completion of the current mem_rd/mem_wr.

Function
REQ-017 States: IDLE, ACK_WAIT, RD_FETCH, RD_PUSH, WR_ADDR, WR_STORE, DONE.
REQ-018 IDLE: lowest-index channel with sd_rd|sd_wr set is selected; its lba latched; op latched (sd_wr wins if both set); go ACK_WAIT with delay counter = ACK_DELAY.
REQ-019 Requests are sampled only in IDLE; changes on any request line during a transfer are ignored.
REQ-020 ACK_WAIT: counter decrements each cycle; at 0, sd_ack[sel] asserts, sd_buff_addr=0, go RD_FETCH (read) or WR_ADDR (write); ACK_DELAY=0 asserts ack on the cycle after acceptance.
REQ-021 RD_FETCH: mem_rd=1, mem_addr={lba,sd_buff_addr}; on mem_ready capture mem_rdata into sd_buff_dout, drop mem_rd, go RD_PUSH.
REQ-022 RD_PUSH: sd_buff_wr=1 for exactly one cycle; if sd_buff_addr=511 go DONE else increment sd_buff_addr, go RD_FETCH.
REQ-023 WR_ADDR: one wait cycle for sd_buff_din of selected channel; go WR_STORE.
REQ-024 WR_STORE: mem_wr=1, mem_wdata = latched din byte, mem_addr={lba,sd_buff_addr}; on mem_ready drop mem_wr; if addr=511 go DONE else increment addr, go WR_ADDR.
REQ-025 sd_buff_addr is 9-bit and never wraps inside a transfer; exactly 512 bytes per transfer.
REQ-026 DONE: sd_ack deasserts on entry; one cycle later return to IDLE (min 1 cycle ack-low before next acceptance).
REQ-027 mem_rd and mem_wr never both high; never high outside RD_FETCH/WR_STORE.
REQ-028 sd_buff_wr never asserted during write transfers.
REQ-029 mem_ready while neither mem_rd nor mem_wr is high is ignored.

Reset
REQ-030 On reset: state IDLE, sd_ack=0, sd_buff_addr=0, sd_buff_dout=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, delay counter=0.
REQ-031 Reset mid-transfer aborts immediately; no further mem or buff strobes; after release the block accepts requests only from IDLE sampling.

Verification
REQ-032 Read, ch1, lba=0x10, mem_ready 1 cycle after each mem_rd, mem_rdata=offset[7:0] -> sd_ack=3'b010 after ACK_DELAY, 512 sd_buff_wr pulses, addr 0..511, dout==addr[7:0], mem_addr=(0x10<<9)+addr, ack then low.
REQ-033 Write, ch0, lba=5, din=~addr[7:0] (1-cycle latency) -> 512 mem_wr with mem_wdata==~offset, no sd_buff_wr, ack drops after byte 511.
REQ-034 sd_rd[0] and sd_rd[2] set same cycle -> ch0 served first, ch2 served after ch0 ack low >=1 cycle.
REQ-035 sd_rd and sd_wr both set on ch2 -> write performed; mem_rd never high.
REQ-036 Reset asserted at byte 200 of a read -> all outputs 0 same cycle; after release with no requests, stays IDLE, no mem strobes.
REQ-037 mem_ready held off 10 cycles per byte -> mem_rd stays high and mem_addr stable until ready; byte count still exactly 512.

Source files
------------

// File: rtl/sd_block_responder.sv
// sd_block_responder: serves 512-byte block reads/writes for VDNUM virtual-disk channels from a byte-wide backing store
module sd_block_responder #(
  parameter int VDNUM     = 3,
  parameter int ACK_DELAY = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [32*VDNUM-1:0]  sd_lba,
  input  logic [VDNUM-1:0]     sd_rd,
  input  logic [VDNUM-1:0]     sd_wr,
  output logic [VDNUM-1:0]     sd_ack,
  output logic [8:0]           sd_buff_addr,
  output logic [7:0]           sd_buff_dout,
  input  logic [8*VDNUM-1:0]   sd_buff_din,
  output logic                 sd_buff_wr,
  output logic [40:0]          mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready
);
  typedef enum logic [2:0] {IDLE, ACK_WAIT, RD_FETCH, RD_PUSH, WR_ADDR, WR_STORE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0]       sel_q, sel_d, req_sel;
  logic [31:0]      lba_q, lba_d;
  logic             wr_q, wr_d;
  logic [7:0]       cnt_q, cnt_d, din_sel;
  logic [8:0]       addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic [VDNUM-1:0] ack_q, ack_d, req;
  assign req          = sd_rd | sd_wr;
  assign din_sel      = sd_buff_din[{sel_q, 3'd0} +: 8];
  assign sd_ack       = ack_q;
  assign sd_buff_addr = addr_q;
  assign sd_buff_dout = dout_q;
  assign sd_buff_wr   = state_q == RD_PUSH;
  assign mem_rd       = state_q == RD_FETCH;
  assign mem_wr       = state_q == WR_STORE;
  assign mem_addr     = (mem_rd || mem_wr) ? {lba_q, addr_q} : '0;
  assign mem_wdata    = mem_wr ? din_sel : '0;
  // lowest-index requesting channel wins arbitration
  always_comb begin
    req_sel = '0;
    for (int n = VDNUM - 1; n >= 0; n--) if (req[n]) req_sel = 2'(n);
  end
  // transfer sequencing: accept, delay ack, then 512 fetch/push or addr/store steps
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lba_d   = lba_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: if (|req) begin
        sel_d   = req_sel;
        lba_d   = sd_lba[{req_sel, 5'd0} +: 32];
        wr_d    = sd_wr[req_sel];
        cnt_d   = 8'(ACK_DELAY);
        state_d = ACK_WAIT;
      end
      ACK_WAIT: if (cnt_q == 8'd0) begin
        ack_d   = VDNUM'(1) << sel_q;
        addr_d  = '0;
        state_d = wr_q ? WR_ADDR : RD_FETCH;
      end else cnt_d = cnt_q - 8'd1;
      RD_FETCH: if (mem_ready) begin
        dout_d  = mem_rdata;
        state_d = RD_PUSH;
      end
      RD_PUSH: begin
        ack_d   = (addr_q == 9'd511) ? '0 : ack_q;
        addr_d  = (addr_q == 9'd511) ? addr_q : addr_q + 9'd1;
        state_d = (addr_q == 9'd511) ? DONE : RD_FETCH;
      end
      WR_ADDR: state_d = WR_STORE;
      WR_STORE: if (mem_ready) begin
        ack_d   = (addr_q == 9'd511) ? '0 : ack_q;
        addr_d  = (addr_q == 9'd511) ? addr_q : addr_q + 9'd1;
        state_d = (addr_q == 9'd511) ? DONE : WR_ADDR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared immediately by reset
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      lba_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lba_q   <= lba_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_sd_block_responder.sv
// tb_sd_block_responder: directed table-driven bench for sd_block_responder
module tb_sd_block_responder;
  localparam int VDNUM = 3;
  localparam int ACK_DELAY = 4;
  logic clk_sys = 1'b0, reset = 1'b0;
  logic [32*VDNUM-1:0] sd_lba = '0;
  logic [VDNUM-1:0] sd_rd = '0, sd_wr = '0, sd_ack;
  logic [8:0] sd_buff_addr;
  logic [7:0] sd_buff_dout, mem_wdata, mem_rdata;
  logic [8*VDNUM-1:0] sd_buff_din = '0;
  logic sd_buff_wr, mem_rd, mem_wr, mem_ready;
  logic [40:0] mem_addr;
  int checks = 0, failures = 0;
  int lat = 0, wait_cnt = 0;
  int n_bwr, n_mem, bwr_bad, addr_bad, data_bad, both_hi, rd_cyc, wr_cyc, ack_bad;
  logic [1:0] cur_ch = '0;
  logic [31:0] cur_lba = '0;
  logic [VDNUM-1:0] exp_ack = '0;
  sd_block_responder #(.VDNUM(VDNUM), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );
  always #5 clk_sys = ~clk_sys;
  assign mem_rdata = mem_addr[7:0];
  // requester: registered write data, channel n returns ~addr ^ (0x11*n)
  always @(posedge clk_sys)
    sd_buff_din <= {~sd_buff_addr[7:0] ^ 8'h22, ~sd_buff_addr[7:0] ^ 8'h11, ~sd_buff_addr[7:0]};
  // backing store: ready pulse lat+1 cycles after a request appears
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_ready) mem_ready <= 1'b0;
    else if (mem_rd || mem_wr) begin
      if (wait_cnt >= lat) begin
        mem_ready <= 1'b1;
        wait_cnt <= 0;
      end else wait_cnt <= wait_cnt + 1;
    end
  end
  // monitor: tallies protocol errors against the expected byte sequence
  always @(negedge clk_sys) if (!reset) begin
    if (mem_rd && mem_wr) both_hi++;
    if (mem_rd) rd_cyc++;
    if (mem_wr) wr_cyc++;
    if (sd_ack != '0 && sd_ack != exp_ack) ack_bad++;
    if (sd_buff_wr) begin
      if (sd_buff_addr != n_bwr[8:0] || sd_buff_dout != n_bwr[7:0]) bwr_bad++;
      n_bwr++;
    end
    if (mem_rd || mem_wr) begin
      if (mem_addr != {cur_lba, n_mem[8:0]}) addr_bad++;
      if (mem_wr && mem_wdata != (~n_mem[7:0] ^ (8'h11 * {6'd0, cur_ch}))) data_bad++;
      if (mem_ready) n_mem++;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic clr();
    {n_bwr, n_mem, bwr_bad, addr_bad, data_bad, both_hi, rd_cyc, wr_cyc, ack_bad} = '0;
  endtask
  task automatic start(input logic [2:0] rd, input logic [2:0] wr, input int ch,
                       input logic [31:0] lba, input int l, input string nm);
    int c = 0;
    lat = l;
    cur_ch = 2'(ch);
    cur_lba = lba;
    exp_ack = 3'(1 << ch);
    clr();
    for (int n = 0; n < VDNUM; n++) sd_lba[32*n +: 32] = (n == ch) ? lba : 32'hDEAD_0000 + n;
    sd_rd = rd;
    sd_wr = wr;
    do begin
      @(posedge clk_sys); #1;
      c++;
    end while (sd_ack == '0 && c < 100);
    chk({nm, "_ack_latency"}, c, ACK_DELAY + 2);
    chk({nm, "_ack"}, sd_ack, exp_ack);
    sd_rd = '0;
    sd_wr = '0;
  endtask
  task automatic finish_xfer(input logic wr_op, input string nm);
    int c = 0;
    while (sd_ack != '0 && c < 512 * (lat + 4) + 100) begin
      @(posedge clk_sys); #1;
      c++;
    end
    chk({nm, "_ack_low"}, sd_ack, 0);
    chk({nm, "_mem_bytes"}, n_mem, 512);
    chk({nm, "_buff_wr_pulses"}, n_bwr, wr_op ? 0 : 512);
    chk({nm, "_buff_bad"}, bwr_bad, 0);
    chk({nm, "_mem_addr_bad"}, addr_bad, 0);
    chk({nm, "_wdata_bad"}, data_bad, 0);
    chk({nm, "_rd_wr_overlap"}, both_hi, 0);
    chk({nm, "_wrong_strobe"}, wr_op ? rd_cyc : wr_cyc, 0);
    chk({nm, "_ack_value_bad"}, ack_bad, 0);
  endtask
  typedef struct {
    logic [2:0] rd;
    logic [2:0] wr;
    int ch;
    logic [31:0] lba;
    logic wr_op;
    int lat;
    string nm;
  } vec_t;
  vec_t vecs[6];
  initial begin
    int c;
    vecs[0] = '{3'b010, 3'b000, 1, 32'h10, 1'b0, 0, "rd_ch1"};
    vecs[1] = '{3'b000, 3'b001, 0, 32'h5, 1'b1, 0, "wr_ch0"};
    vecs[2] = '{3'b100, 3'b100, 2, 32'h77, 1'b1, 0, "rdwr_ch2"};
    vecs[3] = '{3'b110, 3'b000, 1, 32'hABCD_1234, 1'b0, 0, "rd_ch12"};
    vecs[4] = '{3'b000, 3'b110, 1, 32'h42, 1'b1, 2, "wr_ch12"};
    vecs[5] = '{3'b100, 3'b000, 2, 32'h99, 1'b0, 10, "rd_slow"};
    clr();
    #1 reset = 1'b1;
    #2;
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_outputs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_rd, mem_wr, mem_wdata}, 0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].rd, vecs[i].wr, vecs[i].ch, vecs[i].lba, vecs[i].lat, vecs[i].nm);
      finish_xfer(vecs[i].wr_op, vecs[i].nm);
      repeat (3) @(posedge clk_sys);
      #1;
    end
    start(3'b101, 3'b000, 0, 32'h20, 0, "prio_ch0");
    sd_rd = 3'b100;
    finish_xfer(1'b0, "prio_ch0");
    clr();
    cur_ch = 2'd2;
    cur_lba = 32'hDEAD_0002;
    exp_ack = 3'b100;
    c = 0;
    while (sd_ack == '0 && c < 100) begin
      @(posedge clk_sys); #1;
      c++;
    end
    chk("prio_gap", c, ACK_DELAY + 3);
    chk("prio_ch2_ack", sd_ack, 3'b100);
    sd_rd = '0;
    finish_xfer(1'b0, "prio_ch2");
    repeat (3) @(posedge clk_sys);
    #1;
    start(3'b010, 3'b000, 1, 32'h33, 0, "rst");
    c = 0;
    while (n_bwr < 200 && c < 5000) begin
      @(negedge clk_sys);
      c++;
    end
    chk("rst_reached_byte200", 64'(n_bwr >= 200), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_outputs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_rd, mem_wr, mem_wdata}, 0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    clr();
    repeat (20) @(posedge clk_sys);
    #1;
    chk("rst_idle_mem_strobes", rd_cyc + wr_cyc, 0);
    chk("rst_idle_buff_wr", n_bwr, 0);
    chk("rst_idle_ack", sd_ack, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule
